// File: rtl/mem_cmd_pkg.sv
// mem_cmd_pkg
//   Shared definitions for the SPI-to-memory command arbiter: default
//   widths, host command opcodes, FSM state encoding and requester indices.
package mem_cmd_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;

    localparam logic [7:0] CMD_READ   = 8'h01;
    localparam logic [7:0] CMD_WRITE  = 8'h02;
    localparam logic [7:0] CMD_STATUS = 8'h03;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

    // Bit positions in the arbiter request/grant vectors.
    localparam int REQ_PB   = 0;
    localparam int REQ_HOST = 1;

    function automatic logic is_mem_cmd(input logic [7:0] cmd);
        return (cmd == CMD_READ) || (cmd == CMD_WRITE);
    endfunction

endpackage

// File: rtl/arb2_rr.sv
// arb2_rr
//   Two-way round-robin arbiter. A lone requester is always granted; when
//   both request, the one not granted most recently wins. The last-grant
//   state resets to the playback side (bit 0), so the first contested cycle
//   after reset goes to the host (bit 1).
// Ports
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-high reset
//   req_i  : request vector {host, playback}
//   gnt_o  : one-hot grant, combinational from req_i and last-grant state
module arb2_rr (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic last_host_q;
    logic last_host_d;

    always_comb begin
        gnt_o       = 2'b00;
        last_host_d = last_host_q;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_host_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
        if (gnt_o != 2'b00) begin
            last_host_d = gnt_o[1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_host_q <= 1'b0;
        end else begin
            last_host_q <= last_host_d;
        end
    end

endmodule

// File: rtl/mem_cmd_arbiter.sv
// mem_cmd_arbiter
//   Turns SPI command frames into single-port memory accesses and shares the
//   memory port with a playback read requester through arb2_rr.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | no frame held
//   ARMED  | frame held, waiting for the latch strobe
//   ACCESS | host access latched, waiting for (and taking) the grant
//
// Ports
//   wb_clk_i, wb_rst_i      : clock, synchronous active-high reset
//   enable                  : chip enable; low forces IDLE and blocks grants
//   frame_valid, frame_data : received frame {cmd, addr, wdata}
//   latch                   : commit strobe for the held frame
//   rsp_valid, rsp_data     : host read response (data held until next read)
//   pb_req, pb_addr, pb_gnt : playback read request / combinational grant
//   pb_rvalid, pb_rdata     : playback read data, two cycles after grant
//   mem_*                   : single-port memory, one-cycle read latency
//   busy                    : high in ARMED and ACCESS
//   cmd_err                 : one-cycle pulse on latch of an unknown command
//
// Build option
//   MEM_CMD_STATUS_EN : adds command 0x03, returning {err_cnt, frame_cnt}
//                       as a host response without touching memory.
module mem_cmd_arbiter
    import mem_cmd_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic                       enable,
    input  logic                       frame_valid,
    input  logic [8+ADDR_W+DATA_W-1:0] frame_data,
    input  logic                       latch,
    output logic                       rsp_valid,
    output logic [DATA_W-1:0]          rsp_data,
    input  logic                       pb_req,
    input  logic [ADDR_W-1:0]          pb_addr,
    output logic                       pb_gnt,
    output logic                       pb_rvalid,
    output logic [DATA_W-1:0]          pb_rdata,
    output logic                       mem_en,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic [DATA_W-1:0]          mem_rdata,
    output logic                       busy,
    output logic                       cmd_err
);

    localparam int FRAME_W = 8 + ADDR_W + DATA_W;

    state_e              state_q, state_d;
    logic [FRAME_W-1:0]  frame_q, frame_d;
    // A frame arrived while the host access was still waiting or in flight.
    logic                pend_q, pend_d;
    // The access itself is copied out of the hold register on latch so a
    // newer frame cannot alter an access that is already committed.
    logic                acc_we_q, acc_we_d;
    logic [ADDR_W-1:0]   acc_addr_q, acc_addr_d;
    logic [DATA_W-1:0]   acc_wdata_q, acc_wdata_d;
    logic                cmd_err_q, cmd_err_d;

    logic                host_rd_q;
    logic                pb_rd_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic                pb_rvalid_q;
    logic [DATA_W-1:0]   pb_rdata_q;

    logic [7:0]          held_cmd;
    logic [ADDR_W-1:0]   held_addr;
    logic [DATA_W-1:0]   held_wdata;
    logic                req_en;
    logic [1:0]          req;
    logic [1:0]          gnt;
    logic                host_gnt;

    logic                status_sel;
    logic [DATA_W-1:0]   status_word;

    assign {held_cmd, held_addr, held_wdata} = frame_q;

    // Requests are masked while disabled or in reset so the port is quiet.
    assign req_en        = enable & ~wb_rst_i;
    assign req[REQ_HOST] = req_en & (state_q == ST_ACCESS);
    assign req[REQ_PB]   = req_en & pb_req;
    assign host_gnt      = gnt[REQ_HOST];

    arb2_rr u_arb (
        .clk_i (wb_clk_i),
        .rst_i (wb_rst_i),
        .req_i (req),
        .gnt_o (gnt)
    );

`ifdef MEM_CMD_STATUS_EN
    logic       st_rd_d, st_rd_q;
    logic [7:0] err_cnt_q;
    logic [7:0] frame_cnt_q;

    assign status_sel  = st_rd_q;
    assign status_word = DATA_W'({err_cnt_q, frame_cnt_q});

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            st_rd_q     <= 1'b0;
            err_cnt_q   <= 8'd0;
            frame_cnt_q <= 8'd0;
        end else begin
            st_rd_q <= st_rd_d;
            if (cmd_err_d && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
            if (enable && frame_valid && (frame_cnt_q != 8'hFF)) begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
        end
    end
`else
    assign status_sel  = 1'b0;
    assign status_word = '0;
`endif

    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        pend_d      = pend_q;
        acc_we_d    = acc_we_q;
        acc_addr_d  = acc_addr_q;
        acc_wdata_d = acc_wdata_q;
        cmd_err_d   = 1'b0;
`ifdef MEM_CMD_STATUS_EN
        st_rd_d     = 1'b0;
`endif
        if (!enable) begin
            state_d = ST_IDLE;
            frame_d = '0;
            pend_d  = 1'b0;
        end else begin
            if (frame_valid) begin
                frame_d = frame_data;
            end
            case (state_q)
                ST_IDLE: begin
                    if (frame_valid) begin
                        state_d = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (latch) begin
                        // Latch commits the frame held before this cycle;
                        // a frame arriving alongside it stays held.
                        acc_addr_d  = held_addr;
                        acc_wdata_d = held_wdata;
                        acc_we_d    = (held_cmd == CMD_WRITE);
                        pend_d      = frame_valid;
                        if (is_mem_cmd(held_cmd)) begin
                            state_d = ST_ACCESS;
`ifdef MEM_CMD_STATUS_EN
                        end else if (held_cmd == CMD_STATUS) begin
                            st_rd_d = 1'b1;
                            state_d = frame_valid ? ST_ARMED : ST_IDLE;
`endif
                        end else begin
                            cmd_err_d = 1'b1;
                            state_d   = frame_valid ? ST_ARMED : ST_IDLE;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (frame_valid) begin
                        pend_d = 1'b1;
                    end
                    if (host_gnt) begin
                        state_d = (pend_q || frame_valid) ? ST_ARMED : ST_IDLE;
                        pend_d  = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        pb_gnt    = gnt[REQ_PB];
        mem_en    = |gnt;
        mem_we    = host_gnt & acc_we_q;
        mem_addr  = '0;
        mem_wdata = '0;
        if (host_gnt) begin
            mem_addr = acc_addr_q;
        end else if (gnt[REQ_PB]) begin
            mem_addr = pb_addr;
        end
        if (host_gnt && acc_we_q) begin
            mem_wdata = acc_wdata_q;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign cmd_err   = cmd_err_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign pb_rvalid = pb_rvalid_q;
    assign pb_rdata  = pb_rdata_q;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            frame_q     <= '0;
            pend_q      <= 1'b0;
            acc_we_q    <= 1'b0;
            acc_addr_q  <= '0;
            acc_wdata_q <= '0;
            cmd_err_q   <= 1'b0;
            host_rd_q   <= 1'b0;
            pb_rd_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            pb_rvalid_q <= 1'b0;
            pb_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            pend_q      <= pend_d;
            acc_we_q    <= acc_we_d;
            acc_addr_q  <= acc_addr_d;
            acc_wdata_q <= acc_wdata_d;
            cmd_err_q   <= cmd_err_d;
            // Read pipeline runs regardless of enable so granted reads finish.
            host_rd_q   <= host_gnt & ~acc_we_q;
            pb_rd_q     <= gnt[REQ_PB];
            rsp_valid_q <= host_rd_q | status_sel;
            if (host_rd_q) begin
                rsp_data_q <= mem_rdata;
            end else if (status_sel) begin
                rsp_data_q <= status_word;
            end
            pb_rvalid_q <= pb_rd_q;
            if (pb_rd_q) begin
                pb_rdata_q <= mem_rdata;
            end
        end
    end

endmodule

// File: doc/mem_cmd_arbiter.md
MEM_CMD_ARBITER -- requirements
Module: mem_cmd_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, memory word address width.
REQ-002 SHALL have parameter DATA_W, default 16, memory word width.
REQ-003 SHALL have port wb_clk_i  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port wb_rst_i  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port enable  in  1  synchronized chip enable (active-high).
REQ-006 SHALL have port frame_valid  in  1  one-cycle pulse: SPI frame received.
REQ-007 SHALL have port frame_data  in  8+ADDR_W+DATA_W  {cmd[7:0], addr, wdata}.
REQ-008 SHALL have port latch  in  1  one-cycle pulse: synchronized latch strobe (commit).
REQ-009 SHALL have ports rsp_valid out 1 and rsp_data out DATA_W: host read response for the SPI TX shifter.
REQ-010 SHALL have ports pb_req in 1, pb_addr in ADDR_W, pb_gnt out 1, pb_rvalid out 1, pb_rdata out DATA_W: playback read requester.
REQ-011 SHALL have ports mem_en, mem_we out 1, mem_addr out ADDR_W, mem_wdata out DATA_W, mem_rdata in DATA_W: single-port memory with 1-cycle read latency.
REQ-012 SHALL have ports busy out 1 and cmd_err out 1 (one-cycle pulse).

Function
REQ-013 SHALL implement FSM IDLE, ARMED, ACCESS.
REQ-014 SHALL, on frame_valid in IDLE or ARMED, hold frame_data and enter ARMED; a newer frame overwrites the held one (last wins).
REQ-015 SHALL, on latch in ARMED with cmd 0x01 (read) or 0x02 (write), enter ACCESS next cycle; latch in IDLE or ACCESS is ignored.
REQ-016 SHALL, on latch in ARMED with any other cmd, pulse cmd_err next cycle and return to IDLE.
REQ-017 SHALL arbitrate the memory port each cycle between host (state ACCESS) and pb_req; with one requester it is granted; with both, the requester not granted last wins (2-way round-robin); last-grant resets to playback.
REQ-018 SHALL, on grant, drive mem_en=1, mem_addr, and for host write mem_we=1, mem_wdata in that same cycle; mem_en=0 when no grant.
REQ-019 SHALL assert pb_gnt combinationally in the playback grant cycle G; pb_rvalid/pb_rdata registered, valid in G+2 only.
REQ-020 SHALL, for host read granted in G, present rsp_data with rsp_valid pulse in G+2; rsp_data holds until the next host read.
REQ-021 SHALL return to IDLE the cycle after host grant; uncontested latch at T gives mem_en at T+1, read rsp_valid at T+3.
REQ-022 SHALL accept frame_valid during ACCESS into the hold register without disturbing the in-flight access; FSM then goes to ARMED instead of IDLE.
REQ-023 SHALL, while enable=0: drive mem_en=0, pb_gnt=0, ignore frame_valid/latch, force FSM to IDLE and drop held frame; reads already granted still complete their G+2 valid.
REQ-024 SHALL drive busy=1 in ARMED and ACCESS.

Reset
REQ-025 SHALL on wb_rst_i set FSM IDLE, last-grant playback, all outputs 0, rsp_data/pb_rdata 0, held frame cleared, in-flight read valids cancelled.

Configuration
REQ-026 SHALL, with MEM_CMD_STATUS_EN defined, decode cmd 0x03 as status read: no memory access, rsp_valid at T+2 with rsp_data={err_cnt[7:0], frame_cnt[7:0]} (saturating counts of cmd_err pulses and frame_valid accepts, zero on reset).
REQ-027 SHALL, without MEM_CMD_STATUS_EN, treat 0x03 as unknown (REQ-016) and contain no counters.

Structure
REQ-028 SHALL place cmd opcodes (0x01, 0x02, 0x03), FSM state enum and default widths in package mem_cmd_pkg.
REQ-029 SHALL instantiate sub-module arb2_rr (2-way round-robin arbiter: req[1:0], last-grant state, gnt[1:0]).

Verification
REQ-030 SHALL cover write: frame 0x02_00_FACE, latch -> mem_we=1, addr 0x00, wdata 0xFACE at T+1; then frame 0x01_00_0000, latch -> rsp_data 0xFACE at T+3.
REQ-031 SHALL cover contention: host ACCESS and pb_req (addr 0x05) same cycle, last grant host -> playback granted first, host next cycle; both rvalids follow at G+2.
REQ-032 SHALL cover overwrite: frames 0x02_01_DEAD then 0x02_02_BEEF before latch -> only addr 0x02 written with 0xBEEF.
REQ-033 SHALL cover errors: latch with cmd 0x7F -> cmd_err pulse, no mem_en; latch in IDLE -> no effect.
REQ-034 SHALL cover enable drop in ARMED -> IDLE, held frame dropped, later latch ignored; reset in ACCESS -> all outputs 0 next cycle.
REQ-035 SHALL cover, with MEM_CMD_STATUS_EN, after 3 frames and 1 error, cmd 0x03 -> rsp_data 0x0103.
